if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined core. Owns the PC, drives the instruction-memory address, and latches fetched instructions into IF/ID. Consumes `stall` and `hlt_out` from the hazard detection unit and branch redirects from ID. Holds, flushes or halts fetch accordingly.

Parameters:
- PC_W, 16, PC and instruction-address width.
- INSTR_W, 16, instruction width.
- RESET_PC, 16'h0000, PC value on reset.
- NOP_INSTR, 16'h0000, instruction word driven into IF/ID for a bubble.

Ports:
- clk, input, 1, core clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- stall, input, 1, from the hazard unit; hold PC and IF/ID.
- hlt, input, 1, from the hazard unit's hlt_out; the HLT has reached the end of the pipe.
- branch_taken, input, 1, from ID; redirect fetch.
- branch_target, input, PC_W, redirect address.
- imem_addr, output, PC_W, instruction-memory address; equals PC.
- imem_data, input, INSTR_W, instruction at imem_addr, combinational, same cycle.
- if_id_instr, output, INSTR_W, latched instruction.
- if_id_pc_plus2, output, PC_W, latched PC+2 of that instruction.
- if_id_valid, output, 1, 0 means bubble.
- halted, output, 1, core is halted; sticky until reset.

Behaviour:
- Reset (rst=0, asynchronous):
  - PC = RESET_PC.
  - if_id_instr = NOP_INSTR, if_id_pc_plus2 = 0, if_id_valid = 0, halted = 0.
  - State = RUN.
- Arithmetic: pc_plus2 = PC + 2, modulo 2^PC_W. 16'hFFFE + 2 wraps to 16'h0000 with no flag.
- imem_addr = PC, combinational. Fetch latency: an instruction appears on the IF/ID outputs one cycle after its PC is presented.
- State machine, states RUN, HLT_SEEN, HALTED:
  - RUN, priority order each edge:
    1. stall=1: PC and IF/ID hold unchanged. branch_taken is ignored, because the branch is re-presented next cycle.
    2. branch_taken=1: PC <= branch_target; IF/ID <= bubble (NOP_INSTR, valid=0).
    3. Otherwise: IF/ID <= {imem_data, pc_plus2, valid=1}.
       - If imem_data[15:12] == 4'hF (HLT): PC holds and state -> HLT_SEEN.
       - Else: PC <= pc_plus2.
  - HLT_SEEN: PC frozen at the HLT address.
    - stall=1: hold everything.
    - branch_taken=1 and stall=0: the HLT was on the wrong path. PC <= branch_target, IF/ID <= bubble, state -> RUN.
    - Otherwise: IF/ID <= bubble each cycle.
  - HALTED: PC held, IF/ID <= bubble, halted=1. stall and branch_taken are ignored. Exit only by reset.
  - Any state with hlt=1: state -> HALTED next edge, halted=1 from that edge. hlt has priority over branch_taken and stall.
- A HLT fetched while stall=1 is not latched and does not change state until it is accepted.
- if_id_valid=0 entries must carry NOP_INSTR so the hazard unit sees no false opcode match.
- Reset asserted mid-operation, including in HALTED, returns every state element to its reset value immediately.

Decomposition:
- Shared package (cpu_pkg):
  - Opcode constants: OP_LW=4'h8, OP_SW=4'h9, OP_LHB=4'hA, OP_LLB=4'hB, OP_HLT=4'hF.
  - NOP_INSTR.
  - Fetch state enum {RUN, HLT_SEEN, HALTED} as 2-bit encoding.
- One sub-module, pc_reg: PC_W-bit register with write enable and asynchronous active-low reset to RESET_PC. Instantiated once for the PC. The IF/ID fields use the same cell type.

Test Plan:
1. Reset release, imem returns 16'h1123 at PC 0 and 16'h2456 at PC 2, no stall → imem_addr goes 0, 2, 4; IF/ID shows {16'h1123, pc_plus2=2, valid=1} then {16'h2456, 4, 1}.
2. Stall held 2 cycles with PC=6 → imem_addr stays 6; IF/ID unchanged for both cycles; fetch resumes at 6 after stall drops.
3. branch_taken=1, branch_target=16'h0040 with stall=0 → next cycle imem_addr=16'h0040 and IF/ID valid=0 with NOP_INSTR. Same branch with stall=1 → no redirect.
4. imem_data=16'hF000 at PC 16'h0010 → IF/ID latches HLT, PC stays 16'h0010, following cycles are bubbles. hlt asserted 3 cycles later → halted=1 next edge; later branch_taken is ignored.
5. HLT fetched at 16'h0020, then branch_taken to 16'h0100 before hlt → state returns to RUN, imem_addr=16'h0100, halted stays 0.
6. PC=16'hFFFE, non-HLT instruction → imem_addr wraps to 16'h0000. rst pulsed low asynchronously while halted → halted=0, PC=RESET_PC without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, bubble word and fetch states shared by the 16-bit core
package cpu_pkg;
  localparam logic [3:0] OP_LW = 4'h8;
  localparam logic [3:0] OP_SW = 4'h9;
  localparam logic [3:0] OP_LHB = 4'hA;
  localparam logic [3:0] OP_LLB = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  typedef enum logic [1:0] {RUN = 2'd0, HLT_SEEN = 2'd1, HALTED = 2'd2} fetch_state_e;
endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// pc_reg: enabled register with asynchronous active-low reset to RST_VAL
module pc_reg #(
  parameter int W = 16,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= RST_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, instruction fetch and IF/ID register with stall, redirect and halt
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int INSTR_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               hlt,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc_plus2,
  output logic               if_id_valid,
  output logic               halted
);
  localparam int IFID_W = INSTR_W + PC_W + 1;
  fetch_state_e state, state_n;
  logic [PC_W-1:0] pc, pc_d, pc_plus2;
  logic pc_en, ifid_en, is_hlt;
  logic [IFID_W-1:0] ifid_d, ifid_q;
  assign pc_plus2 = pc + PC_W'(2);
  assign is_hlt = imem_data[INSTR_W-1 -: 4] == OP_HLT;
  assign imem_addr = pc;
  assign {if_id_instr, if_id_pc_plus2, if_id_valid} = ifid_q;
  assign halted = state == HALTED;
  pc_reg #(.W(PC_W), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .en(pc_en), .d(pc_d), .q(pc)
  );
  pc_reg #(.W(IFID_W), .RST_VAL({NOP_INSTR, {PC_W{1'b0}}, 1'b0})) u_if_id (
    .clk(clk), .rst(rst), .en(ifid_en), .d(ifid_d), .q(ifid_q)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RUN;
    else state <= state_n;
  // hlt outranks everything; a fetched HLT freezes PC until a redirect or the halt arrives
  always_comb begin
    state_n = state;
    pc_en = 1'b0;
    pc_d = branch_target;
    ifid_en = 1'b0;
    ifid_d = {NOP_INSTR, if_id_pc_plus2, 1'b0};
    if (hlt || state == HALTED) begin
      state_n = HALTED;
      ifid_en = 1'b1;
    end else if (!stall) begin
      ifid_en = 1'b1;
      if (branch_taken) begin
        pc_en = 1'b1;
        state_n = RUN;
      end else if (state == RUN) begin
        ifid_d = {imem_data, pc_plus2, 1'b1};
        pc_en = !is_hlt;
        pc_d = pc_plus2;
        state_n = is_hlt ? HLT_SEEN : RUN;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed and random fetch traffic against a behavioural fetch model
module tb_if_fetch_stage;
  logic clk = 0, rst = 0, stall = 0, hlt = 0, branch_taken = 0;
  logic [15:0] branch_target = 0, imem_addr, imem_data, if_id_instr, if_id_pc_plus2;
  logic if_id_valid, halted;
  logic [15:0] mem [0:255];
  logic [15:0] m_pc, m_instr, m_pp2;
  logic m_valid, m_halted, m_seen;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr[8:1]];

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .hlt(hlt), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_instr(if_id_instr), .if_id_pc_plus2(if_id_pc_plus2),
    .if_id_valid(if_id_valid), .halted(halted)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
    m_valid = 0; m_halted = 0; m_seen = 0;
  endtask

  task automatic bubble();
    m_instr = 16'h0000; m_valid = 0;
  endtask

  // Fetch rules applied to the pre-edge model state and the inputs seen at the edge
  task automatic model_step();
    logic [15:0] d;
    if (hlt || m_halted) begin
      m_halted = 1; bubble();
    end else if (!stall) begin
      if (branch_taken) begin
        m_pc = branch_target; m_seen = 0; bubble();
      end else if (m_seen) bubble();
      else begin
        d = mem[m_pc[8:1]];
        m_instr = d; m_pp2 = m_pc + 16'd2; m_valid = 1;
        if (d[15:12] == 4'hF) m_seen = 1;
        else m_pc = m_pc + 16'd2;
      end
    end
  endtask

  task automatic cycle(input logic s, input logic h, input logic b, input logic [15:0] t);
    stall = s; hlt = h; branch_taken = b; branch_target = t;
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  always @(negedge clk) begin
    chk("imem_addr", imem_addr, m_pc);
    chk("valid", {15'd0, if_id_valid}, {15'd0, m_valid});
    chk("instr", if_id_instr, m_instr);
    if (m_valid) chk("pc_plus2", if_id_pc_plus2, m_pp2);
    chk("halted", {15'd0, halted}, {15'd0, m_halted});
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'h3000; mem[3] = 16'h4000;
    mem[8] = 16'hF000; mem[16] = 16'hF0AB; mem[32] = 16'h1111;
    mem[128] = 16'h1234; mem[255] = 16'h5555;
    model_reset();
    #1 chk("reset_addr", imem_addr, 16'h0000);
    chk("reset_halted", {15'd0, halted}, 16'h0000);
    @(negedge clk); @(negedge clk);
    rst = 1;
    cycle(0, 0, 0, 0);
    chk("t1_instr", if_id_instr, 16'h1123);
    chk("t1_pp2", if_id_pc_plus2, 16'h0002);
    chk("t1_valid", {15'd0, if_id_valid}, 16'h0001);
    chk("t1_addr", imem_addr, 16'h0002);
    cycle(0, 0, 0, 0);
    chk("t1_instr2", if_id_instr, 16'h2456);
    chk("t1_pp2b", if_id_pc_plus2, 16'h0004);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 16'h0080);
    chk("t2_addr", imem_addr, 16'h0006);
    chk("t2_instr", if_id_instr, 16'h3000);
    cycle(0, 0, 1, 16'h0040);
    chk("t3_addr", imem_addr, 16'h0040);
    chk("t3_instr", if_id_instr, 16'h0000);
    chk("t3_valid", {15'd0, if_id_valid}, 16'h0000);
    cycle(1, 0, 1, 16'h0080);
    chk("t3_stall_addr", imem_addr, 16'h0040);
    cycle(0, 0, 1, 16'h0010);
    cycle(0, 0, 0, 0);
    chk("t4_instr", if_id_instr, 16'hF000);
    chk("t4_addr", imem_addr, 16'h0010);
    cycle(0, 0, 0, 0);
    chk("t4_bubble", {15'd0, if_id_valid}, 16'h0000);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    chk("t4_halted", {15'd0, halted}, 16'h0001);
    cycle(0, 0, 1, 16'h0200);
    chk("t4_ignore_br", imem_addr, 16'h0010);
    #2 rst = 0;
    model_reset();
    #1 chk("t6_async_halted", {15'd0, halted}, 16'h0000);
    chk("t6_async_addr", imem_addr, 16'h0000);
    @(negedge clk) rst = 1;
    #1 cycle(0, 0, 1, 16'h0020);
    cycle(0, 0, 0, 0);
    chk("t5_hlt", if_id_instr, 16'hF0AB);
    cycle(0, 0, 1, 16'h0100);
    chk("t5_addr", imem_addr, 16'h0100);
    chk("t5_halted", {15'd0, halted}, 16'h0000);
    cycle(0, 0, 0, 0);
    chk("t5_instr", if_id_instr, 16'h1234);
    cycle(0, 0, 1, 16'hFFFE);
    cycle(0, 0, 0, 0);
    chk("t6_instr", if_id_instr, 16'h5555);
    chk("t6_wrap_addr", imem_addr, 16'h0000);
    chk("t6_wrap_pp2", if_id_pc_plus2, 16'h0000);
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 250) begin
        #2 rst = 0;
        model_reset();
        @(negedge clk) rst = 1;
        #1;
      end
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 4) == 0, 16'($urandom));
    end
    @(negedge clk);
    #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
